// File: rtl/regfile_wb.sv
// Dual-lane register-file writeback buffer: in-order FIFO draining up to two entries per cycle.
// Optional macro REGFILE_WB_BYPASS_EN enables zero-latency bypass when the FIFO is empty.
module regfile_wb #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in0_valid,
  input  logic [4:0]               in0_rd,
  input  logic [31:0]              in0_data,
  input  logic                     in1_valid,
  input  logic [4:0]               in1_rd,
  input  logic [31:0]              in1_data,
  output logic                     in_ready,
  input  logic                     wb_hold,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [31:0]              wd3,
  output logic                     we4,
  output logic [4:0]               wa4,
  output logic [31:0]              wd4,
  input  logic [4:0]               qa,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [PW-1:0] rd_ptr_inc, wr_ptr_second;
  logic          can_drain, bypass;
  logic          enq0, enq1;
  logic [CW-1:0] enq_ext, deq_ext;
  logic [1:0]    deq_cnt;
  logic          src0_v, src1_v;
  logic [4:0]    src0_rd, src1_rd;
  logic [31:0]   src0_data, src1_data;
  logic [DEPTH-1:0] hit;

  assign rd_ptr_inc = rd_ptr_reg + PW'(1);
  assign can_drain  = !reset && !wb_hold;

`ifdef REGFILE_WB_BYPASS_EN
  assign bypass = can_drain && (count_reg == '0);
`else
  assign bypass = 1'b0;
`endif

  assign in_ready = !reset && ((CW'(DEPTH) - count_reg) >= CW'(2));
  assign enq0     = in0_valid && in_ready && !bypass;
  assign enq1     = in1_valid && in_ready && !bypass;
  assign enq_ext  = CW'(enq0) + CW'(enq1);
  assign deq_ext  = CW'(deq_cnt);
  assign wr_ptr_second = enq0 ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

  // Select the two write candidates: bypassed lanes or the FIFO head pair.
  always_comb begin
    src0_v    = 1'b0;
    src0_rd   = '0;
    src0_data = '0;
    src1_v    = 1'b0;
    src1_rd   = '0;
    src1_data = '0;
    deq_cnt   = 2'd0;
    if (bypass) begin
      src0_v    = in0_valid;
      src0_rd   = in0_rd;
      src0_data = in0_data;
      src1_v    = in1_valid;
      src1_rd   = in1_rd;
      src1_data = in1_data;
    end else if (can_drain) begin
      if (count_reg >= CW'(1)) begin
        src0_v    = 1'b1;
        src0_rd   = mem_rd[rd_ptr_reg];
        src0_data = mem_data[rd_ptr_reg];
        deq_cnt   = 2'd1;
      end
      if (count_reg >= CW'(2)) begin
        src1_v    = 1'b1;
        src1_rd   = mem_rd[rd_ptr_inc];
        src1_data = mem_data[rd_ptr_inc];
        deq_cnt   = 2'd2;
      end
    end
  end

  // Older write is suppressed when the younger one targets the same register.
  assign we3 = src0_v && (src0_rd != '0) && !(src1_v && (src1_rd == src0_rd));
  assign we4 = src1_v && (src1_rd != '0);
  assign wa3 = we3 ? src0_rd   : '0;
  assign wd3 = we3 ? src0_data : '0;
  assign wa4 = we4 ? src1_rd   : '0;
  assign wd4 = we4 ? src1_data : '0;

  always_ff @(posedge clk) begin
    if (enq0) begin
      mem_rd[wr_ptr_reg]   <= in0_rd;
      mem_data[wr_ptr_reg] <= in0_data;
    end
    if (enq1) begin
      mem_rd[wr_ptr_second]   <= in1_rd;
      mem_data[wr_ptr_second] <= in1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(enq_ext);
      rd_ptr_reg <= rd_ptr_reg + PW'(deq_cnt);
      count_reg  <= count_reg + enq_ext - deq_ext;
    end
  end

  // An entry is live when its distance from the head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] age;
    assign age     = PW'(gi) - rd_ptr_reg;
    assign hit[gi] = ({1'b0, age} < count_reg) && (mem_rd[gi] == qa);
  end

  assign q_pending = !reset && (qa != '0) && (|hit);
  assign count     = count_reg;
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: queue-based model compared every cycle plus directed literal checks.
module tb_regfile_wb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_valid, in1_valid, wb_hold, in_ready;
  logic [4:0]  in0_rd, in1_rd, qa, wa3, wa4;
  logic [31:0] in0_data, in1_data, wd3, wd4;
  logic        we3, we4, q_pending;
  logic [2:0]  count;

  always #5 clk = ~clk;

  regfile_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_rd(in0_rd), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data),
    .in_ready(in_ready), .wb_hold(wb_hold),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .qa(qa), .q_pending(q_pending), .count(count)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf [32];
  int          wcount = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          cmp_en = 0;

  // Model expectations for the current cycle
  bit          e_ready, e_byp, e_we3, e_we4, e_qp;
  int          e_deq;
  ent_t        e_a, e_b;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_eval();
    int   n;
    bit   a_v, b_v;
    n     = q.size();
    a_v   = 0;
    b_v   = 0;
    e_a   = '0;
    e_b   = '0;
    e_deq = 0;
    e_ready = !reset && (DEPTH - n >= 2);
`ifdef REGFILE_WB_BYPASS_EN
    e_byp = !reset && !wb_hold && (n == 0);
`else
    e_byp = 0;
`endif
    if (e_byp) begin
      a_v = in0_valid; e_a = {in0_rd, in0_data};
      b_v = in1_valid; e_b = {in1_rd, in1_data};
    end else if (!reset && !wb_hold) begin
      e_deq = (n > 2) ? 2 : n;
      a_v = (n >= 1);
      b_v = (n >= 2);
      if (a_v) e_a = q[0];
      if (b_v) e_b = q[1];
    end
    e_we3 = a_v && (e_a.rd != 0) && !(b_v && e_b.rd == e_a.rd);
    e_we4 = b_v && (e_b.rd != 0);
    e_qp  = 0;
    if (!reset && qa != 0)
      foreach (q[i]) if (q[i].rd == qa) e_qp = 1;
  endfunction

  // Compare at negedge, advance the model at posedge.
  always begin
    @(negedge clk);
    model_eval();
    if (cmp_en) begin
      chk("m_in_ready", in_ready, e_ready);
      chk("m_count", count, q.size());
      chk("m_we3", we3, e_we3);
      chk("m_wa3", wa3, e_we3 ? e_a.rd : 0);
      chk("m_wd3", wd3, e_we3 ? e_a.data : 0);
      chk("m_we4", we4, e_we4);
      chk("m_wa4", wa4, e_we4 ? e_b.rd : 0);
      chk("m_wd4", wd4, e_we4 ? e_b.data : 0);
      chk("m_q_pending", q_pending, e_qp);
    end
    if (we3 === 1'b1) begin rf[wa3] = wd3; wcount++; end
    if (we4 === 1'b1) begin rf[wa4] = wd4; wcount++; end
    @(posedge clk);
    model_eval();
    if (reset) q.delete();
    else begin
      repeat (e_deq) void'(q.pop_front());
      if (e_ready && !e_byp) begin
        if (in0_valid) q.push_back({in0_rd, in0_data});
        if (in1_valid) q.push_back({in1_rd, in1_data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    in0_valid = 0; in0_rd = 0; in0_data = 0;
    in1_valid = 0; in1_rd = 0; in1_data = 0;
  endtask

  task automatic set_pair(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
  endtask

  initial begin
    int wc;
    foreach (rf[i]) rf[i] = '0;
    reset = 1; wb_hold = 0; qa = 0;
    idle_lanes();
    step(); step();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Single write
    set_pair(1, 5'd5, 32'h11, 0, 0, 0);
    step(); idle_lanes();
`ifndef REGFILE_WB_BYPASS_EN
    @(negedge clk);
    chk("single_we3", we3, 1);
    chk("single_wa3", wa3, 5);
    chk("single_wd3", wd3, 32'h11);
    chk("single_we4", we4, 0);
`endif
    step();
    @(negedge clk);
    chk("single_count", count, 0);

    // Same destination pair: younger wins
    step();
    set_pair(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
    step(); idle_lanes();
`ifndef REGFILE_WB_BYPASS_EN
    @(negedge clk);
    chk("same_we3", we3, 0);
    chk("same_we4", we4, 1);
    chk("same_wa4", wa4, 7);
    chk("same_wd4", wd4, 32'hBBBB);
`endif
    step();
    @(negedge clk);
    chk("same_rf_x7", rf[7], 32'hBBBB);

    // x0 filtering
    step();
    set_pair(1, 5'd0, 32'hFFFF, 1, 5'd3, 32'h3);
    step(); idle_lanes();
`ifndef REGFILE_WB_BYPASS_EN
    @(negedge clk);
    chk("x0_we3", we3, 0);
    chk("x0_we4", we4, 1);
    chk("x0_wa4", wa4, 3);
`endif
    step();
    @(negedge clk);
    chk("x0_count", count, 0);

    // Hold and fill
    step();
    wb_hold = 1;
    set_pair(1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
    step();
    set_pair(1, 5'd3, 32'h303, 1, 5'd4, 32'h404);
    step();
    set_pair(1, 5'd5, 32'h505, 1, 5'd6, 32'h606);
    @(negedge clk);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    step(); idle_lanes();
    @(negedge clk);
    chk("fill_ignored_count", count, 4);
    step();
    wb_hold = 0;
    @(negedge clk);
    chk("drain1_wa3", wa3, 1);
    chk("drain1_wd3", wd3, 32'h101);
    chk("drain1_wa4", wa4, 2);
    step();
    @(negedge clk);
    chk("drain2_count", count, 2);
    chk("drain2_in_ready", in_ready, 1);
    chk("drain2_wa3", wa3, 3);
    chk("drain2_wa4", wa4, 4);
    step();
    @(negedge clk);
    chk("drain_done_count", count, 0);

    // Hazard query
    step();
    wb_hold = 1; qa = 5'd9;
    set_pair(1, 5'd9, 32'h99, 0, 0, 0);
    @(negedge clk);
    chk("qp_presented", q_pending, 0);
    step(); idle_lanes();
    @(negedge clk);
    chk("qp_buffered", q_pending, 1);
    qa = 5'd0; #1;
    chk("qp_qa0", q_pending, 0);
    wb_hold = 0; qa = 5'd9; #1;
    chk("qp_draining", q_pending, 1);
    step();
    @(negedge clk);
    chk("qp_after_drain", q_pending, 0);

    // Reset mid-stream
    step();
    wb_hold = 1; qa = 5'd10;
    set_pair(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    step();
    set_pair(1, 5'd12, 32'hC0, 0, 0, 0);
    step(); idle_lanes();
    @(negedge clk);
    chk("mid_count", count, 3);
    wc = wcount;
    reset = 1; wb_hold = 0; #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_we3", we3, 0);
    chk("mid_rst_we4", we4, 0);
    chk("mid_rst_q_pending", q_pending, 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("mid_after_count", count, 0);
    chk("mid_no_writes", wcount, wc);
    qa = 0;

`ifdef REGFILE_WB_BYPASS_EN
    step();
    set_pair(1, 5'd4, 32'h44, 0, 0, 0);
    #1;
    chk("byp_we3", we3, 1);
    chk("byp_wa3", wa3, 4);
    chk("byp_wd3", wd3, 32'h44);
    step(); idle_lanes();
    @(negedge clk);
    chk("byp_count", count, 0);
`endif

    // Directed mixed stream, checked by the model each cycle
    for (int i = 0; i < 40; i++) begin
      set_pair((i % 3) != 0, 5'(i % 8), 32'(i * 16 + 1),
               (i % 2) == 0, 5'((i * 3) % 8), 32'(i * 16 + 2));
      wb_hold = ((i % 7) == 5) || ((i % 11) == 3);
      qa = 5'((i + 1) % 8);
      step();
    end
    idle_lanes();
    wb_hold = 0; qa = 0;
    repeat (4) step();
    @(negedge clk);
    chk("stream_final_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter DEPTH, default 4, buffer entries; SHALL be an even power of two, minimum 4.
REQ-002 clk  input  1  rising-edge clock; reset is synchronous and active-high.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in0_valid, in0_rd, in0_data  input  1/5/32  lane-0 retiring result; lane 0 is older.
REQ-005 in1_valid, in1_rd, in1_data  input  1/5/32  lane-1 retiring result; lane 1 is younger.
REQ-006 in_ready  output  1  high when both lanes can be accepted this cycle.
REQ-007 wb_hold  input  1  high blocks all register-file writes this cycle.
REQ-008 we3, wa3, wd3  output  1/5/32  register-file write port 3, for the older drained entry.
REQ-009 we4, wa4, wd4  output  1/5/32  register-file write port 4, for the younger drained entry.
REQ-010 qa  input  5  hazard query register address.
REQ-011 q_pending  output  1  high when a buffered, undrained entry targets qa and qa is not 0.
REQ-012 count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-013 Buffer SHALL be an in-order FIFO of {rd, data} entries.
- A lane is enqueued on a clock edge when its valid and in_ready are both high.
- When both lanes are enqueued, lane 0 SHALL be stored ahead of lane 1.
- in1_valid without in0_valid SHALL enqueue a single entry.
REQ-014 in_ready SHALL equal (DEPTH - count >= 2) and !reset, based on count before the current cycle's drain.
REQ-015 Valid lanes presented while in_ready is low SHALL be ignored; the producer holds them.
REQ-016 Drain when wb_hold is low:
- count >= 2: the two oldest entries drain, the oldest to port 3 and the next to port 4.
- count == 1: only the head drains, on port 3; we4 = 0.
REQ-017 Drain when wb_hold is high: no entry drains, and we3 = we4 = 0.
REQ-018 Drain ports SHALL be driven combinationally from the FIFO head; enqueue-to-write latency is 1 cycle minimum.
REQ-019 An entry with rd == 0 SHALL be consumed with its port's we low.
REQ-020 If both drained entries have the same nonzero rd, we3 SHALL be 0 and the entry on port 4 alone is written, so the younger write wins; both entries are consumed.
REQ-021 wa/wd SHALL be 0 whenever the corresponding we is 0.
REQ-022 Enqueue and drain in the same cycle SHALL both take effect.
- count_next = count + enq - deq.
- Pointers wrap modulo DEPTH.
REQ-023 q_pending SHALL be combinational over all valid entries, including entries draining this cycle.
- It SHALL exclude lanes being presented this cycle.
REQ-024 count SHALL never exceed DEPTH.
REQ-025 Dequeue SHALL never occur from an empty FIFO.

Reset
REQ-026 On a clock edge with reset high:
- FIFO is emptied and pointers are set to 0.
- count = 0.
- Inputs on that edge are discarded.
REQ-027 While reset is high: we3 = we4 = 0, wa/wd = 0, q_pending = 0, in_ready = 0.
REQ-028 Reset asserted mid-stream SHALL drop all buffered entries without any register-file write.

Configuration
REQ-029 Macro REGFILE_WB_BYPASS_EN, when defined, enables zero-latency bypass. Bypass applies when all of these hold:
- count == 0
- wb_hold is low
- reset is low
Under bypass, valid lanes SHALL drive the ports combinationally in the same cycle and SHALL NOT be stored:
- lane 0 drives port 3, lane 1 drives port 4.
- REQ-019 to REQ-021 apply.
REQ-030 Without REGFILE_WB_BYPASS_EN, every entry passes through the FIFO with 1-cycle minimum latency.

Verification
REQ-031 Single write, no bypass: in0 = {x5, 0x11} at cycle 0, wb_hold = 0 -> cycle 1: we3 = 1, wa3 = 5, wd3 = 0x11, we4 = 0; cycle 2: count = 0.
REQ-032 Same-destination pair: in0 = {x7, 0xAAAA}, in1 = {x7, 0xBBBB} -> next cycle: we3 = 0, we4 = 1, wa4 = 7, wd4 = 0xBBBB; final x7 = 0xBBBB.
REQ-033 Hold and fill (DEPTH = 4): wb_hold = 1, two dual-lane enqueues -> count = 4, in_ready = 0; a third pair is ignored.
- Release hold: 2 entries drain per cycle in order, and in_ready = 1 after the first drain.
REQ-034 x0 filtering: in0 = {x0, 0xFFFF}, in1 = {x3, 0x3} -> we3 = 0, we4 = 1, wa4 = 3; count returns to 0.
REQ-035 Hazard query: buffer holds x9 under wb_hold = 1, qa = 9 -> q_pending = 1; qa = 0 -> 0; after drain -> 0.
REQ-036 Reset mid-stream: count = 3, assert reset for 1 cycle -> count = 0, no we pulses, in_ready = 0 during reset.
- With REGFILE_WB_BYPASS_EN: an empty-FIFO enqueue of {x4, 0x44} gives we3 = 1, wa3 = 4 in the same cycle.
